// File: rtl/lcd_bus_pkg.sv
// Shared types and helpers for the 8080-style LCD bus master.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_LO,
    WR_HI,
    RD_LO,
    RD_HI,
    RST
  } lcd_state_e;

  // A programmed phase length of zero still has to last one cycle.
  function automatic logic [31:0] eff_cnt(input logic [31:0] cfg);
    return (cfg == 32'd0) ? 32'd1 : cfg;
  endfunction

endpackage

// File: rtl/lcd_bus_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; a push is taken only when
// the registered ready is high, so a pop never opens a same-cycle slot.
module lcd_bus_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic                     mclk,
  input  logic                     puc_rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  output logic                     push_rdy_o,
  input  logic                     pop_i,
  output logic [W-1:0]             pop_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   lvl_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   lvl_q, lvl_d;
  logic          rdy_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i & rdy_q;
  assign pop_ok  = pop_i & (lvl_q != '0);

  always_comb begin
    lvl_d = lvl_q;
    if (push_ok && !pop_ok)      lvl_d = lvl_q + 1'b1;
    else if (!push_ok && pop_ok) lvl_d = lvl_q - 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      rdy_q    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      lvl_q <= lvl_d;
      rdy_q <= (lvl_d != FULL_LVL);
    end
  end

  always_ff @(posedge mclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o  = mem_q[rd_ptr_q];
  assign push_rdy_o = rdy_q;
  assign empty_o    = (lvl_q == '0);
  assign lvl_o      = lvl_q;

endmodule

// File: rtl/lcd_bus_engine.sv
// 8080-style LCD bus master: FIFO-buffered command/data writes with programmable
// strobe timing and panel reset pulse; read-back present only with LCD_BUS_RD_EN.
module lcd_bus_engine
  import lcd_bus_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4,
  parameter int RST_CYC    = 1024
) (
  input  logic                          mclk,
  input  logic                          puc_rst,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_rs_i,
  input  logic                          cmd_rd_i,
  input  logic [DATA_W-1:0]             cmd_data_i,
  output logic                          rsp_valid_o,
  output logic [DATA_W-1:0]             rsp_data_o,
  input  logic [CNT_W-1:0]              cfg_wr_lo_i,
  input  logic [CNT_W-1:0]              cfg_wr_hi_i,
  input  logic [CNT_W-1:0]              cfg_rd_lo_i,
  input  logic [CNT_W-1:0]              cfg_rd_hi_i,
  input  logic                          rst_req_i,
  input  logic                          on_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
  output logic                          lcd_cs_n_o,
  output logic                          lcd_rs_o,
  output logic                          lcd_wr_n_o,
  output logic                          lcd_rd_n_o,
  output logic [DATA_W-1:0]             lcd_d_o,
  output logic                          lcd_d_en_o,
  input  logic [DATA_W-1:0]             lcd_d_i,
  output logic                          lcd_reset_n_o,
  output logic                          lcd_on_o
);

  typedef struct packed {
    logic              rd;
    logic              rs;
    logic [DATA_W-1:0] dat;
  } entry_t;

  localparam int RW = $clog2(RST_CYC + 1);

  entry_t            push_ent, pop_ent;
  logic              rd_req, fifo_empty, pop, last_cnt;
  lcd_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RW-1:0]     rst_cnt_q;
  logic              cs_n_q, rs_q, wr_n_q, d_en_q, reset_n_q, on_q;
  logic [DATA_W-1:0] d_q;
`ifdef LCD_BUS_RD_EN
  logic              rd_q, rd_n_q, rsp_vld_q;
  logic [DATA_W-1:0] rsp_dat_q;
  assign rd_req = cmd_rd_i;
`else
  logic              unused_rd_path;
  assign rd_req = 1'b0;
  assign unused_rd_path = ^{cmd_rd_i, lcd_d_i, cfg_rd_lo_i, cfg_rd_hi_i, pop_ent.rd};
`endif

  assign push_ent = '{rd: rd_req, rs: cmd_rs_i, dat: cmd_data_i};

  lcd_bus_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .push_i     (cmd_valid_i),
    .push_dat_i (push_ent),
    .push_rdy_o (cmd_ready_o),
    .pop_i      (pop),
    .pop_dat_o  (pop_ent),
    .empty_o    (fifo_empty),
    .lvl_o      (fifo_lvl_o)
  );

  assign last_cnt = (cnt_q <= CNT_W'(1));

  // Pops happen from IDLE or on the final high cycle, which is what keeps cs_n low in bursts.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:         pop = !rst_req_i && !fifo_empty;
      WR_HI, RD_HI: pop = last_cnt && !fifo_empty;
      default:      pop = 1'b0;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rst_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      rs_q      <= 1'b0;
      wr_n_q    <= 1'b1;
      d_q       <= '0;
      d_en_q    <= 1'b0;
      reset_n_q <= 1'b1;
      on_q      <= 1'b0;
`ifdef LCD_BUS_RD_EN
      rd_q      <= 1'b0;
      rd_n_q    <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
`endif
    end else begin
      on_q <= on_i;
`ifdef LCD_BUS_RD_EN
      rsp_vld_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (rst_req_i) begin
            state_q   <= RST;
            reset_n_q <= 1'b0;
            rst_cnt_q <= RW'(RST_CYC);
          end
        end
        SETUP: begin
`ifdef LCD_BUS_RD_EN
          if (rd_q) begin
            state_q <= RD_LO;
            rd_n_q  <= 1'b0;
            cnt_q   <= CNT_W'(eff_cnt(32'(cfg_rd_lo_i)));
          end else
`endif
          begin
            state_q <= WR_LO;
            wr_n_q  <= 1'b0;
            cnt_q   <= CNT_W'(eff_cnt(32'(cfg_wr_lo_i)));
          end
        end
        WR_LO: begin
          if (last_cnt) begin
            state_q <= WR_HI;
            wr_n_q  <= 1'b1;
            cnt_q   <= CNT_W'(eff_cnt(32'(cfg_wr_hi_i)));
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef LCD_BUS_RD_EN
        RD_LO: begin
          if (last_cnt) begin
            state_q   <= RD_HI;
            rd_n_q    <= 1'b1;
            rsp_vld_q <= 1'b1;
            rsp_dat_q <= lcd_d_i;
            cnt_q     <= CNT_W'(eff_cnt(32'(cfg_rd_hi_i)));
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RD_HI,
`endif
        WR_HI: begin
          if (last_cnt) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            d_en_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RST: begin
          if (rst_cnt_q <= RW'(1)) begin
            state_q   <= IDLE;
            reset_n_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A pop overrides the exit above and launches the next cycle's setup.
      if (pop) begin
        state_q <= SETUP;
        cs_n_q  <= 1'b0;
        rs_q    <= pop_ent.rs;
        d_en_q  <= !pop_ent.rd;
        if (!pop_ent.rd) d_q <= pop_ent.dat;
`ifdef LCD_BUS_RD_EN
        rd_q <= pop_ent.rd;
`endif
      end
    end
  end

  assign busy_o        = (state_q != IDLE) || !fifo_empty;
  assign lcd_cs_n_o    = cs_n_q;
  assign lcd_rs_o      = rs_q;
  assign lcd_wr_n_o    = wr_n_q;
  assign lcd_d_o       = d_q;
  assign lcd_d_en_o    = d_en_q;
  assign lcd_reset_n_o = reset_n_q;
  assign lcd_on_o      = on_q;
`ifdef LCD_BUS_RD_EN
  assign lcd_rd_n_o  = rd_n_q;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_data_o  = rsp_dat_q;
`else
  assign lcd_rd_n_o  = 1'b1;
  assign rsp_valid_o = 1'b0;
  assign rsp_data_o  = '0;
`endif

endmodule

// File: doc/lcd_bus_engine.md
Name: lcd_bus_engine

Overview:
- Parametrised 8080-style LCD parallel-bus master; next generation of the LT24 bus interface in openGFX430.
- Buffers command/data writes, and optionally reads, in a FIFO.
- Generates CS/RS/WR/RD/D strobes with run-time programmable timing, a timed panel reset pulse and optional read-back.
- Sits between the GFX refresh/peripheral logic (producer) and the panel pads.

Parameters:
- DATA_W, 16: LCD bus width; legal values 8, 16 or 18.
- FIFO_DEPTH, 8: command FIFO entries; power of 2, minimum 2.
- CNT_W, 4: width of the timing counters and timing config fields.
- RST_CYC, 1024: lcd_reset_n_o low duration in mclk cycles.

Ports:
- mclk, in, 1: clock.
- puc_rst, in, 1: synchronous, active-high reset.
- cmd_valid_i, in, 1: push request.
- cmd_ready_o, out, 1: FIFO not full.
- cmd_rs_i, in, 1: 0 = command, 1 = data (drives RS).
- cmd_rd_i, in, 1: 1 = read cycle. Forced 0 without the macro.
- cmd_data_i, in, DATA_W: write data.
- rsp_valid_o, out, 1: one-cycle read-data strobe.
- rsp_data_o, out, DATA_W: captured read data.
- cfg_wr_lo_i, in, CNT_W: WR low cycles.
- cfg_wr_hi_i, in, CNT_W: WR high cycles.
- cfg_rd_lo_i, in, CNT_W: RD low cycles.
- cfg_rd_hi_i, in, CNT_W: RD high cycles.
- rst_req_i, in, 1: start panel reset pulse.
- on_i, in, 1: panel on request.
- busy_o, out, 1: FSM not IDLE or FIFO not empty.
- fifo_lvl_o, out, clog2(FIFO_DEPTH)+1: occupancy.
- lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_rd_n_o, out, 1 each: bus strobes.
- lcd_d_o, out, DATA_W: bus data.
- lcd_d_en_o, out, 1: pad output enable.
- lcd_d_i, in, DATA_W: bus input.
- lcd_reset_n_o, lcd_on_o, out, 1 each: panel control.

Behaviour:
- Reset values, all taken on the first mclk edge with puc_rst high:
  - cs_n = wr_n = rd_n = reset_n = 1.
  - rs = d_en = on = 0; d_o = 0.
  - rsp_valid = 0; rsp_data = 0.
  - FIFO empty; cmd_ready = 1; fifo_lvl = 0.
  - FSM = IDLE.
  - An in-flight cycle is abandoned immediately; no partial strobe persists.
- lcd_on_o: registered copy of on_i (1-cycle latency).
- FIFO:
  - Entry = {rd, rs, data}.
  - Push when cmd_valid_i & cmd_ready_o; cmd_ready_o = !full, registered.
  - Push and pop in the same cycle: level unchanged. When full, pop does not enable a same-cycle push.
  - Pointers wrap modulo FIFO_DEPTH.
- Timing fields: a config value of 0 is treated as 1. Config is sampled when each phase is entered; mid-phase changes do not affect the current phase.
- FSM states, with a down-counter per phase:
  - IDLE: cs_n = 1, d_en = 0.
    - rst_req_i → RST, which has priority over the FIFO.
    - Else FIFO not empty → pop → SETUP.
  - SETUP (1 cycle): cs_n = 0; rs = entry.rs.
    - Write: d_o = data, d_en = 1 → WR_LO.
    - Read: d_en = 0 → RD_LO.
  - WR_LO: wr_n = 0 for cfg_wr_lo cycles → WR_HI.
  - WR_HI: wr_n = 1 and d held for cfg_wr_hi cycles.
    - Then if FIFO not empty: pop → SETUP, cs_n stays 0 (back-to-back burst).
    - Else → IDLE.
  - RD_LO: rd_n = 0 for cfg_rd_lo cycles. lcd_d_i is registered into rsp_data_o on the last RD_LO cycle; rsp_valid_o pulses for 1 cycle on the next edge → RD_HI.
  - RD_HI: rd_n = 1 for cfg_rd_hi cycles, then the same exit rule as WR_HI.
  - RST: reset_n = 0, cs_n = 1 for RST_CYC cycles → IDLE. rst_req_i is ignored while in RST. FIFO pushes continue to be accepted.
- Minimum write cycle = 1 + lo + hi mclk cycles. Example: lo = 2, hi = 1 gives 4 cycles/word.
- rs/d change only in SETUP, never while wr_n or rd_n is low.
- busy_o is combinational from state and empty.

Optional Feature:
- Macro: LCD_BUS_RD_EN.
- Defined: read path present (RD_LO/RD_HI states, rsp_* outputs, lcd_d_i capture).
- Undefined:
  - cmd_rd_i is ignored and entries are always writes.
  - rd_n = 1 constant; rsp_valid_o = 0, rsp_data_o = 0.
  - lcd_d_i is unused.
  - RD states are not synthesised.

Decomposition:
- Package lcd_bus_pkg holds:
  - State enum lcd_state_e {IDLE, SETUP, WR_LO, WR_HI, RD_LO, RD_HI, RST}.
  - Entry struct typedef, parametrised via DATA_W in the module.
  - Function for effective count, max(cfg, 1).
- Sub-module lcd_bus_fifo: synchronous FIFO with level output, instantiated once. The FSM, counters and pad registers stay in lcd_bus_engine.

Test Plan:
- Single write: cfg_wr_lo = 2, cfg_wr_hi = 1; push rs = 1, data = 16'hA5C3 → cs_n low 4 cycles, wr_n low exactly 2 cycles, d_o = A5C3 with d_en = 1 throughout, then IDLE with busy_o = 0.
- Burst plus full FIFO: push 8 entries back-to-back with FIFO_DEPTH = 8 while the engine is stalled by an RST in progress → 9th push sees cmd_ready_o = 0 and fifo_lvl = 8. After RST, 8 write cycles run with cs_n held low continuously; words come out in order.
- Zero config: cfg_wr_lo = 0, cfg_wr_hi = 0 → each write takes 3 cycles (treated as 1/1).
- Reset pulse: rst_req_i for 1 cycle with RST_CYC = 1024 → reset_n low exactly 1024 cycles. A push issued meanwhile executes only afterwards.
- Read (LCD_BUS_RD_EN): cfg_rd_lo = 3; lcd_d_i = 16'h1234 during the last RD_LO cycle → rsp_valid_o pulses once, rsp_data_o = 1234, d_en = 0 throughout the cycle.
- Mid-operation reset: assert puc_rst during WR_LO → next edge gives wr_n = 1, cs_n = 1, FIFO empty, fifo_lvl = 0, cmd_ready_o = 1.
